// File: rtl/dircc_node_mem_stream_reader.sv
// Streams a contiguous run of halfwords from the node processing memory's
// 16-bit port out as one framed Avalon-ST packet. Reads use the memory's fixed
// one-cycle latency and are throttled so every read has a reserved FIFO slot.
module dircc_node_mem_stream_reader #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 16,
  parameter int MEM_WORDS  = 15000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W-1:0]     length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     mem_address,
  output logic                  mem_chipselect,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic                  mem_clken,
  input  logic [DATA_W-1:0]     mem_readdata,
  output logic [DATA_W-1:0]     st_data,
  output logic                  st_valid,
  input  logic                  st_ready,
  output logic                  st_sop,
  output logic                  st_eop
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  // Next halfword address; the memory is not a power of two deep.
  function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + ADDR_W'(1);
  endfunction

  state_t              state;
  logic [ADDR_W-1:0]   len_q;
  logic [ADDR_W-1:0]   issued;
  logic [CNT_W-1:0]    used;     // FIFO entries plus reads not yet pushed
  logic                sop_p0;
  logic                eop_p0;
  logic                vld_p1;
  logic                sop_p1;
  logic                eop_p1;
  logic [DATA_W-1:0]   fifo_data [FIFO_DEPTH];
  logic                fifo_sop  [FIFO_DEPTH];
  logic                fifo_eop  [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count;
  logic                pop;
  logic                room;
  logic                start_issue;
  logic                run_issue;
  logic                issue;

  assign mem_read       = mem_chipselect;
  assign mem_write      = 1'b0;
  assign mem_byteenable = '1;
  assign mem_clken      = 1'b1;

  assign st_valid = (count != '0);
  assign pop      = st_valid & st_ready;
  assign st_data  = st_valid ? fifo_data[rd_ptr] : '0;
  assign st_sop   = st_valid & fifo_sop[rd_ptr];
  assign st_eop   = st_valid & fifo_eop[rd_ptr];

  // A slot freed by this cycle's pop may be reserved by this cycle's issue.
  assign room        = (used < CNT_W'(FIFO_DEPTH)) | pop;
  assign start_issue = (state == S_IDLE) & start & (length != '0);
  assign run_issue   = (state == S_RUN) & (issued != len_q) & room;
  assign issue       = start_issue | run_issue;

  // Stage p0: command FSM and read request generation
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      mem_address    <= '0;
      mem_chipselect <= 1'b0;
      sop_p0         <= 1'b0;
      eop_p0         <= 1'b0;
      len_q          <= '0;
      issued         <= '0;
      used           <= '0;
    end else begin
      done           <= 1'b0;
      mem_chipselect <= 1'b0;
      used           <= used + CNT_W'(issue) - CNT_W'(pop);
      case (state)
        S_IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            len_q <= length;
            if (length == '0) begin
              // Zero-length runs pass through DRAIN so busy shows for a cycle.
              state <= S_DRAIN;
            end else begin
              state          <= S_RUN;
              mem_address    <= base_addr;
              mem_chipselect <= 1'b1;
              sop_p0         <= 1'b1;
              eop_p0         <= (length == ADDR_W'(1));
              issued         <= ADDR_W'(1);
            end
          end
        end
        S_RUN: begin
          if (run_issue) begin
            mem_address    <= wrap_inc(mem_address);
            mem_chipselect <= 1'b1;
            sop_p0         <= 1'b0;
            eop_p0         <= (issued == len_q - ADDR_W'(1));
            issued         <= issued + ADDR_W'(1);
          end else if (issued == len_q) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (used == CNT_W'(pop)) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stage p1: read data returns; FIFO pointer and occupancy control
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1 <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      vld_p1 <= mem_chipselect;
      if (vld_p1) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(vld_p1) - CNT_W'(pop);
    end
  end

  // Stage p1 data path: frame flags follow the request, storage is unreset
  always_ff @(posedge clk) begin
    sop_p1 <= sop_p0;
    eop_p1 <= eop_p0;
    if (vld_p1) begin
      fifo_data[wr_ptr] <= mem_readdata;
      fifo_sop[wr_ptr]  <= sop_p1;
      fifo_eop[wr_ptr]  <= eop_p1;
    end
  end

endmodule

// File: tb/tb_dircc_node_mem_stream_reader.sv
// Bench for dircc_node_mem_stream_reader: table of runs plus hand-written
// sequences for ignored start and mid-run reset, with a beat scoreboard.
module tb_dircc_node_mem_stream_reader;
  localparam int ADDR_W     = 14;
  localparam int DATA_W     = 16;
  localparam int MEM_WORDS  = 15000;
  localparam int FIFO_DEPTH = 4;

  logic                clk = 1'b0;
  logic                reset_n = 1'b1;
  logic                start = 1'b0;
  logic [ADDR_W-1:0]   base_addr = '0;
  logic [ADDR_W-1:0]   length = '0;
  logic                busy, done;
  logic [ADDR_W-1:0]   mem_address;
  logic                mem_chipselect, mem_read, mem_write, mem_clken;
  logic [DATA_W/8-1:0] mem_byteenable;
  logic [DATA_W-1:0]   mem_readdata = '0;
  logic [DATA_W-1:0]   st_data;
  logic                st_valid, st_sop, st_eop;
  logic                st_ready = 1'b1;

  always #5 clk = ~clk;

  dircc_node_mem_stream_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_WORDS(MEM_WORDS), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .length(length), .busy(busy), .done(done), .mem_address(mem_address),
    .mem_chipselect(mem_chipselect), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byteenable(mem_byteenable), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata), .st_data(st_data), .st_valid(st_valid),
    .st_ready(st_ready), .st_sop(st_sop), .st_eop(st_eop)
  );

  // Memory model: data equals address, one-cycle latency, garbage otherwise.
  always @(posedge clk)
    mem_readdata <= mem_chipselect ? DATA_W'(mem_address) : 16'hDEAD;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed { logic [15:0] data; logic sop; logic eop; } beat_t;
  typedef struct { logic [13:0] base; logic [13:0] len; bit bp; int exp_done; } vec_t;

  beat_t exp_q[$];
  int total = 0;
  int bad = 0;
  int cs_cnt, cs_cnt2, pops, run_beats, done_count, done_cyc;
  int first_cs_cyc, first_valid_cyc, occ_viol, stab_viol;
  logic [13:0] cs_base;
  bit hold_pend;
  logic [17:0] hold_val;
  bit bp_mode = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Ready driver: always ready, or a coin toss per cycle under backpressure.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      st_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor sampled on the falling edge.
  always @(negedge clk) begin
    if (reset_n) begin
      if (cs_cnt - pops > FIFO_DEPTH) occ_viol++;
      if (mem_chipselect && (cs_cnt2 - pops >= FIFO_DEPTH)) occ_viol++;
      if (mem_chipselect) begin
        chk("rd_addr", 64'(mem_address), 64'((int'(cs_base) + cs_cnt) % MEM_WORDS));
        if (first_cs_cyc < 0) first_cs_cyc = cyc;
      end
      cs_cnt2 = cs_cnt;
      cs_cnt  = cs_cnt + (mem_chipselect ? 1 : 0);
      if (hold_pend && (!st_valid || {st_data, st_sop, st_eop} != hold_val)) stab_viol++;
      hold_pend = st_valid && !st_ready;
      hold_val  = {st_data, st_sop, st_eop};
      if (st_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (st_valid && st_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL beat_extra actual=%0h required=no beat", st_data);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat", 64'({st_data, st_sop, st_eop}), 64'(e));
        end
        pops++;
        run_beats++;
      end
      if (done) begin
        done_count++;
        done_cyc = cyc;
      end
    end
  end

  task automatic clear_run(input logic [13:0] b, input logic [13:0] len);
    cs_cnt = 0; cs_cnt2 = 0; pops = 0; run_beats = 0; done_count = 0;
    done_cyc = -1; first_cs_cyc = -1; first_valid_cyc = -1;
    occ_viol = 0; stab_viol = 0; hold_pend = 0; cs_base = b;
    exp_q.delete();
    for (int i = 0; i < int'(len); i++) begin
      beat_t e;
      e.data = 16'((int'(b) + i) % MEM_WORDS);
      e.sop  = (i == 0);
      e.eop  = (i == int'(len) - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ctrl"}, 64'({busy, done, mem_chipselect, mem_read, mem_write,
                             st_valid, st_sop, st_eop}), 64'(0));
    chk({tag, "_addr"}, 64'(mem_address), 64'(0));
    chk({tag, "_data"}, 64'(st_data), 64'(0));
    chk({tag, "_tied"}, 64'({mem_byteenable, mem_clken}), 64'(3'b111));
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1.
  task automatic run_vec(input vec_t v, input bit inject, input string tag);
    int t0;
    int k;
    clear_run(v.base, v.len);
    bp_mode = v.bp;
    t0 = cyc;
    start = 1'b1; base_addr = v.base; length = v.len;
    @(posedge clk); #1;
    start = 1'b0; base_addr = 14'($urandom); length = 14'($urandom);
    chk({tag, "_busy"}, 64'(busy), 64'(1));
    if (inject) begin
      @(posedge clk); #1;
      start = 1'b1; base_addr = 14'h0700; length = 14'd3;
      @(posedge clk); #1;
      start = 1'b0;
    end
    k = 0;
    while (done_count == 0 && k < 600) begin
      @(posedge clk); #1;
      k++;
    end
    if (done_count == 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout actual=no done required=done within 600 cycles", tag);
    end
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_done_cnt"}, 64'(done_count), 64'(1));
    chk({tag, "_beats"}, 64'(run_beats), 64'(v.len));
    chk({tag, "_left"}, 64'(exp_q.size()), 64'(0));
    chk({tag, "_idle"}, 64'(busy), 64'(0));
    if (v.len == 0) begin
      chk({tag, "_no_cs"}, 64'(cs_cnt), 64'(0));
    end else begin
      chk({tag, "_cs_lat"}, 64'(first_cs_cyc - t0), 64'(1));
      chk({tag, "_vld_lat"}, 64'(first_valid_cyc - t0), 64'(3));
    end
    if (v.exp_done >= 0) chk({tag, "_done_lat"}, 64'(done_cyc - t0), 64'(v.exp_done));
    chk({tag, "_occupancy"}, 64'(occ_viol), 64'(0));
    chk({tag, "_stable"}, 64'(stab_viol), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[6];
    vec_t v;
    int k;
    int d0;
    vecs[0] = '{14'h0010, 14'd8,  1'b0, 11};
    vecs[1] = '{14'h0200, 14'd20, 1'b1, -1};
    vecs[2] = '{14'd14998, 14'd4, 1'b0, 7};
    vecs[3] = '{14'h0050, 14'd0,  1'b0, 2};
    vecs[4] = '{14'h0123, 14'd1,  1'b0, 4};
    vecs[5] = '{14'd14990, 14'd30, 1'b1, -1};
    clear_run(14'h0, 14'h0);

    #3 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk); #2 reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], 1'b0, $sformatf("vec%0d", i));
    end

    // A start while busy must not disturb the run in progress.
    v = '{14'h0300, 14'd6, 1'b0, -1};
    run_vec(v, 1'b1, "ignored");
    v = '{14'h0700, 14'd3, 1'b0, 6};
    run_vec(v, 1'b0, "after_ignored");

    // Reset in the middle of a run.
    clear_run(14'h0400, 14'd10);
    bp_mode = 1'b0;
    start = 1'b1; base_addr = 14'h0400; length = 14'd10;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (run_beats < 3 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("midrst_streaming", 64'(run_beats >= 3), 64'(1));
    @(negedge clk); #2 reset_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    exp_q.delete();
    d0 = done_count;
    repeat (3) @(posedge clk);
    @(negedge clk); #2 reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_no_done", 64'(done_count), 64'(d0));
    chk("midrst_idle", 64'({busy, mem_chipselect, st_valid}), 64'(0));
    v = '{14'h0100, 14'd2, 1'b0, 5};
    run_vec(v, 1'b0, "post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
